// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with a 2-entry skid buffer,
// synchronous flush and a saturating downstream-starvation counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 128,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [1:0] occ_n;
  logic acc, rel;
  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;
  assign out_valid = occupancy != 2'd0;
  assign out_ctrl = out_valid ? main_ctrl : CTRL_NOP;
  always_comb occ_n = flush ? 2'd0 : occupancy + {1'b0, acc} - {1'b0, rel};
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      occupancy  <= 2'd0;
      in_ready   <= 1'b1;
      main_ctrl  <= CTRL_NOP;
      out_data   <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      bubble_cnt <= '0;
    end else begin
      occupancy <= occ_n;
      in_ready  <= occ_n != 2'd2;
      if (!flush) begin
        if (rel && occupancy == 2'd2) begin
          main_ctrl <= skid_ctrl;
          out_data  <= skid_data;
        end else if (acc && (occupancy == 2'd0 || rel)) begin
          main_ctrl <= in_ctrl;
          out_data  <= in_data;
        end
        if (acc && occupancy == 2'd1 && !rel) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
      if (!out_valid && out_ready && !flush && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus checked against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CW = 8, DW = 32, NW = 4;
  logic clk_50MHz = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0] occupancy;
  logic [NW-1:0] bubble_cnt;
  int total = 0, passed = 0;
  logic [CW+DW-1:0] q[$];
  logic m_ready = 1'b1;
  logic [NW-1:0] m_bub = '0;
  logic [DW-1:0] m_last = '0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_NOP('0), .CNT_W(NW)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string w);
    chk({w, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({w, ".out_ctrl"}, 64'(out_ctrl), q.size() > 0 ? 64'(q[0][CW+DW-1:DW]) : 64'(0));
    chk({w, ".out_data"}, 64'(out_data), q.size() > 0 ? 64'(q[0][DW-1:0]) : 64'(m_last));
    chk({w, ".in_ready"}, 64'(in_ready), 64'(m_ready));
    chk({w, ".occupancy"}, 64'(occupancy), 64'(q.size()));
    chk({w, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bub));
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b1;
    m_bub = '0;
    m_last = '0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then compare.
  task automatic step(input string w, input logic v, input logic [CW-1:0] c, input logic r, input logic f);
    logic acc, rel;
    in_valid = v; in_ctrl = c; in_data = $urandom; out_ready = r; flush = f;
    @(posedge clk_50MHz);
    acc = v && m_ready;
    rel = q.size() > 0 && r;
    if (q.size() == 0 && r && !f && m_bub != '1) m_bub++;
    if (f) q.delete();
    else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back({c, in_data});
    end
    m_ready = q.size() < 2;
    if (q.size() > 0) m_last = q[0][DW-1:0];
    #1 check_all(w);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_50MHz);
    #1 check_all("reset");
    rst = 1'b0;
    repeat (10) step("idle", 1'b0, '0, 1'b1, 1'b0);
    chk("idle.bubble10", 64'(bubble_cnt), 64'd10);
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, CW'(i), 1'b1, 1'b0);
    step("stream_drain", 1'b0, '0, 1'b1, 1'b0);
    repeat (20) step("starve", 1'b0, '0, 1'b1, 1'b0);
    chk("sat.bubble15", 64'(bubble_cnt), 64'd15);
    step("bp_a", 1'b1, 8'h0A, 1'b0, 1'b0);
    step("bp_b", 1'b1, 8'h0B, 1'b0, 1'b0);
    step("bp_c", 1'b1, 8'h0C, 1'b0, 1'b0);
    chk("bp.full_occ", 64'(occupancy), 64'd2);
    chk("bp.full_ready", 64'(in_ready), 64'd0);
    chk("bp.head_a", 64'(out_ctrl), 64'h0A);
    step("bp_c_hold", 1'b1, 8'h0C, 1'b0, 1'b0);
    step("bp_rel_a", 1'b1, 8'h0C, 1'b1, 1'b0);
    chk("bp.head_b", 64'(out_ctrl), 64'h0B);
    chk("bp.ready_after_a", 64'(in_ready), 64'd1);
    step("bp_rel_b", 1'b1, 8'h0C, 1'b1, 1'b0);
    chk("bp.head_c", 64'(out_ctrl), 64'h0C);
    step("bp_rel_c", 1'b0, '0, 1'b1, 1'b0);
    step("fl_1", 1'b1, 8'h01, 1'b0, 1'b0);
    step("fl_2", 1'b1, 8'h02, 1'b0, 1'b0);
    step("fl_d", 1'b1, 8'h0D, 1'b1, 1'b1);
    chk("flush.occ", 64'(occupancy), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.ctrl", 64'(out_ctrl), 64'd0);
    chk("flush.ready", 64'(in_ready), 64'd1);
    step("fl_after", 1'b0, '0, 1'b1, 1'b0);
    repeat (300)
      step("rand", $urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    repeat (2) step("ar_drain", 1'b0, '0, 1'b1, 1'b0);
    step("ar_fill1", 1'b1, 8'h31, 1'b0, 1'b0);
    step("ar_fill2", 1'b1, 8'h32, 1'b0, 1'b0);
    chk("ar.full", 64'(occupancy), 64'd2);
    #4 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #5 rst = 1'b0;
    repeat (40)
      step("post_rst", $urandom_range(0, 1) != 0, CW'($urandom), $urandom_range(0, 2) != 0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
